// File: rtl/lspc_raster_timer.sv
// -----------------------------------------------------------------------------
// lspc_raster_timer
//
// Programmable raster timer and interrupt scheduler for the LSPC video timing
// chain. A down-counter steps once per pixel strobe while enabled. It raises
// a sticky timer interrupt and a one-cycle pulse on each expiry. A sticky
// vertical-blank interrupt is raised on every rising edge of BNK. The CPU
// programs the block through four write-only registers.
//
// Ports:
//   CLK_24M      in   master clock, all state updates on its rising edge
//   RESET        in   asynchronous, active-high reset
//   PIXEL_CE     in   one-cycle pixel strobe (every 4th clock)
//   BNK          in   vertical blank; its 0->1 edge marks frame start
//   CPU_WE       in   register write strobe
//   CPU_ADDR     in   0 = MODE, 1 = RELOAD_HI, 2 = RELOAD_LO, 3 = ACK
//   CPU_DIN      in   16-bit write data
//   IRQ_VBL      out  pending vertical-blank interrupt (sticky level)
//   IRQ_TIMER    out  pending timer interrupt (sticky level)
//   TIMER_ZERO   out  one-cycle pulse on each timer expiry
//   TIMER_COUNT  out  current counter value
//
// CNT_W must be 32 for hardware. Smaller widths (2..32) are for simulation
// only; they keep the low CNT_W bits of the 32-bit reload value.
// -----------------------------------------------------------------------------
module lspc_raster_timer #(
  parameter int CNT_W = 32
) (
  input  logic             CLK_24M,
  input  logic             RESET,
  input  logic             PIXEL_CE,
  input  logic             BNK,
  input  logic             CPU_WE,
  input  logic [1:0]       CPU_ADDR,
  input  logic [15:0]      CPU_DIN,
  output logic             IRQ_VBL,
  output logic             IRQ_TIMER,
  output logic             TIMER_ZERO,
  output logic [CNT_W-1:0] TIMER_COUNT
);

  localparam logic [1:0] ADDR_MODE      = 2'd0;
  localparam logic [1:0] ADDR_RELOAD_HI = 2'd1;
  localparam logic [1:0] ADDR_RELOAD_LO = 2'd2;
  localparam logic [1:0] ADDR_ACK       = 2'd3;

  // Architectural state
  logic [3:0]       mode_r;      // {LD_ZERO, LD_VBL, LD_WRLO, EN}
  logic [31:0]      reload_r;
  logic [CNT_W-1:0] cnt_r;
  logic             bnk_d_r;
  logic             vbl_pend_r;
  logic             tmr_pend_r;
  logic             zero_r;

  // Decoded writes
  logic wr_mode_s;
  logic wr_hi_s;
  logic wr_lo_s;
  logic wr_ack_s;

  // Mode fields
  logic en_s;
  logic ld_wrlo_s;
  logic ld_vbl_s;
  logic ld_zero_s;

  // Event and next-state signals
  logic             frame_start_s;
  logic             wrlo_load_s;
  logic             vbl_load_s;
  logic             step_s;
  logic             expire_s;
  logic [31:0]      wrlo_word_s;
  logic [CNT_W-1:0] wrlo_val_s;
  logic [CNT_W-1:0] reload_val_s;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             vbl_pend_nxt_s;
  logic             tmr_pend_nxt_s;

  assign en_s      = mode_r[0];
  assign ld_wrlo_s = mode_r[1];
  assign ld_vbl_s  = mode_r[2];
  assign ld_zero_s = mode_r[3];

  // The write-load value pairs the current high reload word with the data
  // being written, so the low word lands in the counter on the same edge.
  assign wrlo_word_s  = {reload_r[31:16], CPU_DIN};
  assign wrlo_val_s   = wrlo_word_s[CNT_W-1:0];
  assign reload_val_s = reload_r[CNT_W-1:0];

  assign frame_start_s = BNK & ~bnk_d_r;
  assign wrlo_load_s   = wr_lo_s & ld_wrlo_s;
  assign vbl_load_s    = frame_start_s & ld_vbl_s;
  assign step_s        = PIXEL_CE & en_s;

  // Register write address decode
  always_comb begin
    wr_mode_s = 1'b0;
    wr_hi_s   = 1'b0;
    wr_lo_s   = 1'b0;
    wr_ack_s  = 1'b0;
    if (CPU_WE) begin
      case (CPU_ADDR)
        ADDR_MODE:      wr_mode_s = 1'b1;
        ADDR_RELOAD_HI: wr_hi_s   = 1'b1;
        ADDR_RELOAD_LO: wr_lo_s   = 1'b1;
        ADDR_ACK:       wr_ack_s  = 1'b1;
        default: begin
          wr_mode_s = 1'b0;
          wr_hi_s   = 1'b0;
          wr_lo_s   = 1'b0;
          wr_ack_s  = 1'b0;
        end
      endcase
    end else begin
      wr_mode_s = 1'b0;
      wr_hi_s   = 1'b0;
      wr_lo_s   = 1'b0;
      wr_ack_s  = 1'b0;
    end
  end

  // Counter next state: write load beats VBL load beats the pixel step. A
  // winning load swallows the step, so an expiry can only come from a step.
  always_comb begin
    cnt_nxt_s = cnt_r;
    expire_s  = 1'b0;
    if (wrlo_load_s) begin
      cnt_nxt_s = wrlo_val_s;
    end else if (vbl_load_s) begin
      cnt_nxt_s = reload_val_s;
    end else if (step_s) begin
      if (cnt_r == {CNT_W{1'b0}}) begin
        expire_s = 1'b1;
        if (ld_zero_s) begin
          cnt_nxt_s = reload_val_s;
        end else begin
          cnt_nxt_s = {CNT_W{1'b1}};
        end
      end else begin
        cnt_nxt_s = cnt_r - CNT_W'(1'b1);
      end
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Pending-bit next state: a set in the same cycle as an ACK clear wins.
  always_comb begin
    vbl_pend_nxt_s = vbl_pend_r;
    tmr_pend_nxt_s = tmr_pend_r;
    if (frame_start_s) begin
      vbl_pend_nxt_s = 1'b1;
    end else if (wr_ack_s && CPU_DIN[0]) begin
      vbl_pend_nxt_s = 1'b0;
    end else begin
      vbl_pend_nxt_s = vbl_pend_r;
    end
    if (expire_s) begin
      tmr_pend_nxt_s = 1'b1;
    end else if (wr_ack_s && CPU_DIN[1]) begin
      tmr_pend_nxt_s = 1'b0;
    end else begin
      tmr_pend_nxt_s = tmr_pend_r;
    end
  end

  // MODE and reload registers
  always_ff @(posedge CLK_24M or posedge RESET) begin
    if (RESET) begin
      mode_r   <= 4'h0;
      reload_r <= 32'h0000_0000;
    end else begin
      if (wr_mode_s) begin
        mode_r <= CPU_DIN[7:4];
      end
      if (wr_hi_s) begin
        reload_r[31:16] <= CPU_DIN;
      end
      if (wr_lo_s) begin
        reload_r[15:0] <= CPU_DIN;
      end
    end
  end

  // BNK edge detector; resets high so a BNK already high at reset release
  // is not mistaken for a frame start.
  always_ff @(posedge CLK_24M or posedge RESET) begin
    if (RESET) begin
      bnk_d_r <= 1'b1;
    end else begin
      bnk_d_r <= BNK;
    end
  end

  // Counter, pending interrupts and expiry pulse
  always_ff @(posedge CLK_24M or posedge RESET) begin
    if (RESET) begin
      cnt_r      <= {CNT_W{1'b0}};
      vbl_pend_r <= 1'b0;
      tmr_pend_r <= 1'b0;
      zero_r     <= 1'b0;
    end else begin
      cnt_r      <= cnt_nxt_s;
      vbl_pend_r <= vbl_pend_nxt_s;
      tmr_pend_r <= tmr_pend_nxt_s;
      zero_r     <= expire_s;
    end
  end

  assign IRQ_VBL     = vbl_pend_r;
  assign IRQ_TIMER   = tmr_pend_r;
  assign TIMER_ZERO  = zero_r;
  assign TIMER_COUNT = cnt_r;

endmodule

// File: tb/tb_lspc_raster_timer.sv
// Directed testbench for lspc_raster_timer. Expected values are pushed to a
// scoreboard queue as stimulus is driven and popped when outputs are sampled
// 1 time unit after the active clock edge.
module tb_lspc_raster_timer;

  logic        CLK_24M = 1'b0;
  logic        RESET;
  logic        PIXEL_CE;
  logic        BNK;
  logic        CPU_WE;
  logic [1:0]  CPU_ADDR;
  logic [15:0] CPU_DIN;
  logic        IRQ_VBL;
  logic        IRQ_TIMER;
  logic        TIMER_ZERO;
  logic [31:0] TIMER_COUNT;

  lspc_raster_timer #(.CNT_W(32)) dut (
    .CLK_24M    (CLK_24M),
    .RESET      (RESET),
    .PIXEL_CE   (PIXEL_CE),
    .BNK        (BNK),
    .CPU_WE     (CPU_WE),
    .CPU_ADDR   (CPU_ADDR),
    .CPU_DIN    (CPU_DIN),
    .IRQ_VBL    (IRQ_VBL),
    .IRQ_TIMER  (IRQ_TIMER),
    .TIMER_ZERO (TIMER_ZERO),
    .TIMER_COUNT(TIMER_COUNT)
  );

  always #5 CLK_24M = ~CLK_24M;

  localparam int SEL_CNT  = 0;
  localparam int SEL_ZERO = 1;
  localparam int SEL_VBL  = 2;
  localparam int SEL_TMR  = 3;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;
  logic [31:0] model_c;

  task automatic push(input string tag, input int sel, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic push_all(input string tag, input logic [31:0] cnt,
                          input logic zero, input logic vbl, input logic tmr);
    push({tag, ".count"}, SEL_CNT, cnt);
    push({tag, ".zero"},  SEL_ZERO, {31'd0, zero});
    push({tag, ".vbl"},   SEL_VBL,  {31'd0, vbl});
    push({tag, ".tmr"},   SEL_TMR,  {31'd0, tmr});
  endtask

  // Pop every queued expectation and compare it with the live output.
  task automatic drain();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.sel)
        SEL_CNT:  obs = TIMER_COUNT;
        SEL_ZERO: obs = {31'd0, TIMER_ZERO};
        SEL_VBL:  obs = {31'd0, IRQ_VBL};
        SEL_TMR:  obs = {31'd0, IRQ_TIMER};
        default:  obs = 32'hxxxx_xxxx;
      endcase
      total = total + 1;
      assert (obs === e.val) passed = passed + 1;
      else $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
    end
  endtask

  task automatic clk1();
    @(posedge CLK_24M);
    #1;
  endtask

  task automatic wr(input logic [1:0] addr, input logic [15:0] data, input logic pce);
    CPU_WE   = 1'b1;
    CPU_ADDR = addr;
    CPU_DIN  = data;
    PIXEL_CE = pce;
    clk1();
    CPU_WE   = 1'b0;
    PIXEL_CE = 1'b0;
  endtask

  // One pixel (4 clocks): checks count/pulse after the strobe edge and that
  // the pulse has dropped one edge later.
  task automatic pix_chk(input string tag, input logic [31:0] cnt, input logic zero);
    push({tag, ".count"}, SEL_CNT, cnt);
    push({tag, ".zero"}, SEL_ZERO, {31'd0, zero});
    PIXEL_CE = 1'b1;
    clk1();
    PIXEL_CE = 1'b0;
    drain();
    push({tag, ".zero_fall"}, SEL_ZERO, 32'd0);
    clk1();
    drain();
    clk1();
    clk1();
  endtask

  task automatic pix();
    PIXEL_CE = 1'b1;
    clk1();
    PIXEL_CE = 1'b0;
    clk1();
    clk1();
    clk1();
  endtask

  initial begin
    RESET    = 1'b1;
    PIXEL_CE = 1'b0;
    BNK      = 1'b0;
    CPU_WE   = 1'b0;
    CPU_ADDR = 2'd0;
    CPU_DIN  = 16'h0000;
    clk1();
    clk1();
    RESET = 1'b0;
    clk1();
    push_all("reset", 32'h0, 1'b0, 1'b0, 1'b0);
    drain();

    // Periodic expiry: R = 3, EN + LD_ZERO. C starts at 0 so the first
    // pixel expires, then every 4th pixel.
    wr(2'd1, 16'h0000, 1'b0);
    wr(2'd2, 16'h0003, 1'b0);
    wr(2'd0, 16'h0090, 1'b0);
    model_c = 32'h0;
    for (int p = 0; p < 9; p++) begin
      logic z;
      z = (model_c == 32'h0);
      model_c = z ? 32'h3 : model_c - 32'h1;
      push("periodic.tmr", SEL_TMR, 32'd1);
      pix_chk($sformatf("periodic%0d", p), model_c, z);
    end
    wr(2'd3, 16'h0002, 1'b0);
    push_all("ack_tmr", 32'h3, 1'b0, 1'b0, 1'b0);
    drain();

    // Wrap without reload: force C = 0, then EN only.
    wr(2'd0, 16'h0030, 1'b0);
    wr(2'd1, 16'h0000, 1'b0);
    wr(2'd2, 16'h0000, 1'b0);
    push("wrap.setup", SEL_CNT, 32'h0);
    drain();
    wr(2'd0, 16'h0010, 1'b0);
    pix_chk("wrap1", 32'hFFFF_FFFF, 1'b1);
    pix_chk("wrap2", 32'hFFFF_FFFE, 1'b0);

    // Write reload coinciding with a pixel strobe.
    wr(2'd0, 16'h0030, 1'b0);
    wr(2'd1, 16'h0001, 1'b0);
    push("wrlo.count", SEL_CNT, 32'hFFFF_FFFE);
    drain();
    wr(2'd2, 16'h0010, 1'b1);
    push("wrlo.load", SEL_CNT, 32'h0001_0010);
    push("wrlo.zero", SEL_ZERO, 32'd0);
    drain();
    pix_chk("wrlo.step", 32'h0001_000F, 1'b0);

    // VBL load and interrupt.
    wr(2'd3, 16'h0003, 1'b0);
    push_all("ack_both", 32'h0001_000F, 1'b0, 1'b0, 1'b0);
    drain();
    wr(2'd0, 16'h0050, 1'b0);
    wr(2'd1, 16'h0000, 1'b0);
    wr(2'd2, 16'h0100, 1'b0);
    push("vbl.noload", SEL_CNT, 32'h0001_000F);
    drain();
    BNK = 1'b1;
    clk1();
    push("vbl.irq", SEL_VBL, 32'd1);
    push("vbl.load", SEL_CNT, 32'h0000_0100);
    drain();
    for (int i = 0; i < 250; i++) pix();
    push("vbl.hold.count", SEL_CNT, 32'h0000_0006);
    push("vbl.hold.irq", SEL_VBL, 32'd1);
    drain();
    wr(2'd3, 16'h0001, 1'b0);
    push("vbl.ack", SEL_VBL, 32'd0);
    drain();
    for (int i = 0; i < 5; i++) clk1();
    push("vbl.no_reraise", SEL_VBL, 32'd0);
    drain();
    BNK = 1'b0;
    clk1();

    // Expiry and ACK in the same cycle: set wins. R = 0 gives an expiry on
    // every pixel.
    wr(2'd0, 16'h00B0, 1'b0);
    wr(2'd1, 16'h0000, 1'b0);
    wr(2'd2, 16'h0000, 1'b0);
    push("sim.setup.count", SEL_CNT, 32'h0);
    push("sim.setup.tmr", SEL_TMR, 32'd0);
    drain();
    push("sim.first.tmr", SEL_TMR, 32'd1);
    pix_chk("sim.first", 32'h0, 1'b1);
    wr(2'd3, 16'h0002, 1'b1);
    push_all("sim.ack_vs_expiry", 32'h0, 1'b1, 1'b0, 1'b1);
    drain();
    clk1();

    // VBL edge and LO write in the same cycle: write value wins over old R.
    wr(2'd0, 16'h0070, 1'b0);
    wr(2'd1, 16'h00AB, 1'b0);
    BNK = 1'b1;
    wr(2'd2, 16'h1234, 1'b1);
    push_all("sim.vbl_vs_wrlo", 32'h00AB_1234, 1'b0, 1'b1, 1'b1);
    drain();

    // Asynchronous reset mid-operation.
    wr(2'd1, 16'h0000, 1'b0);
    wr(2'd2, 16'h1234, 1'b0);
    push_all("prereset", 32'h0000_1234, 1'b0, 1'b1, 1'b1);
    drain();
    #3;
    RESET = 1'b1;
    #1;
    push_all("async_reset", 32'h0, 1'b0, 1'b0, 1'b0);
    drain();
    @(posedge CLK_24M);
    #1;
    RESET = 1'b0;   // BNK still high across release
    clk1();
    clk1();
    push("release.bnk_high.vbl", SEL_VBL, 32'd0);
    drain();
    pix_chk("release.disabled", 32'h0, 1'b0);
    BNK = 1'b0;
    clk1();
    BNK = 1'b1;
    clk1();
    push_all("release.new_frame", 32'h0, 1'b0, 1'b1, 1'b0);
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
